// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, same-cycle instruction memory read, IF/ID pipeline register.
// Optional macro PC_BOUNDS_EN confines the PC to the first MEM_BYTES bytes of instruction memory.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instruction,
    output logic [31:0] PC_address,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] seq_pc;
    logic [31:0] redirect_pc;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef PC_BOUNDS_EN
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    logic [32:0] pc_plus4_wide;

    // Compare in 33 bits so a PC near the top of the address space still wraps to 0.
    assign pc_plus4_wide = {1'b0, pc_q} + 33'd4;
    assign seq_pc        = (pc_plus4_wide >= MEM_LIMIT) ? 32'd0 : pc_plus4;
    assign redirect_pc   = (branch_target % 32'(MEM_BYTES)) & WORD_MASK;
`else
    assign seq_pc      = pc_plus4;
    assign redirect_pc = branch_target & WORD_MASK;
`endif

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (branch_taken) begin
            // Squash the word fetched this cycle; it belongs to the wrong path.
            pc_d       = redirect_pc;
            instr_d    = 32'd0;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            pc_d       = seq_pc;
            instr_d    = instruction;
            pc_plus4_d = pc_plus4;
            valid_d    = 1'b1;
            count_d    = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC & WORD_MASK;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign PC_address        = pc_q;
    assign IF_ID_instruction = instr_q;
    assign IF_ID_PC_plus4    = pc_plus4_q;
    assign IF_ID_valid       = valid_q;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random reset/branch/stall traffic
// against a cycle-level reference model of the fetch rules.
module tb_instruction_fetch;

    localparam int unsigned MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instruction;
    logic [31:0] PC_address;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_PC_plus4;
    logic        IF_ID_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_p4, m_cnt;
    logic        m_valid;

    instruction_fetch #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .instruction       (instruction),
        .PC_address        (PC_address),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_PC_plus4    (IF_ID_PC_plus4),
        .IF_ID_valid       (IF_ID_valid),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory is word-addressed by the low address bits (64 words of 4 bytes).
    assign instruction = mem[PC_address[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return mem[addr[7:2]];
    endfunction

    function automatic logic [31:0] next_seq(input logic [31:0] pc);
        longint unsigned nxt;
        nxt = longint'(pc) + 4;
`ifdef PC_BOUNDS_EN
        if (nxt >= MEM_BYTES) nxt = 0;
`endif
        return 32'(nxt);
    endfunction

    function automatic logic [31:0] redirect(input logic [31:0] tgt);
        longint unsigned t;
        t = longint'(tgt);
`ifdef PC_BOUNDS_EN
        t = t % MEM_BYTES;
`endif
        return 32'((t / 4) * 4);
    endfunction

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
        if (r) begin
            m_pc = 32'h0; m_instr = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
        end else if (b) begin
            m_pc = redirect(t); m_instr = 0; m_p4 = 0; m_valid = 0;
        end else if (!s) begin
            m_instr = mem_word(m_pc);
            m_p4    = m_pc + 32'd4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = next_seq(m_pc);
        end
        @(posedge clk);
        #1;
        check("pc",    PC_address,        m_pc);
        check("instr", IF_ID_instruction, m_instr);
        check("p4",    IF_ID_PC_plus4,    m_p4);
        check("valid", 32'(IF_ID_valid),  32'(m_valid));
        check("count", fetch_count,       m_cnt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h02114020;
        mem[1] = 32'h02534822;

        // reset state
        cycle(1, 0, 0, 0);
        check("rst_pc", PC_address, 32'h0);
        check("rst_cnt", fetch_count, 32'h0);

        // two free-running fetches
        cycle(0, 0, 0, 0);
        check("f1_instr", IF_ID_instruction, 32'h02114020);
        check("f1_p4", IF_ID_PC_plus4, 32'd4);
        cycle(0, 0, 0, 0);
        check("f2_instr", IF_ID_instruction, 32'h02534822);
        check("f2_p4", IF_ID_PC_plus4, 32'd8);
        check("f2_pc", PC_address, 32'd8);
        check("f2_cnt", fetch_count, 32'd2);

        // stall three cycles at PC=8, then resume
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        check("stall_pc", PC_address, 32'd8);
        check("stall_cnt", fetch_count, 32'd2);
        cycle(0, 0, 0, 0);
        check("resume_p4", IF_ID_PC_plus4, 32'd12);

        // advance to PC=20 and branch to 32
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("at20", PC_address, 32'd20);
        cycle(0, 0, 1, 32'd32);
        check("br_pc", PC_address, 32'd32);
        check("br_valid", 32'(IF_ID_valid), 32'd0);
        cycle(0, 0, 0, 0);
        check("br_instr", IF_ID_instruction, mem[8]);
        check("br_p4", IF_ID_PC_plus4, 32'd36);

        // branch beats stall, target realigned
        cycle(0, 1, 1, 32'h00000013);
        check("brst_pc", PC_address, 32'h10);
        check("brst_valid", 32'(IF_ID_valid), 32'd0);

        // end of memory window
        cycle(0, 0, 1, 32'd252);
        cycle(0, 0, 0, 0);
`ifdef PC_BOUNDS_EN
        check("bound_pc", PC_address, 32'd0);
`else
        check("bound_pc", PC_address, 32'd256);
`endif

`ifndef PC_BOUNDS_EN
        // 32-bit PC wrap
        cycle(0, 0, 1, 32'hFFFFFFFC);
        cycle(0, 0, 0, 0);
        check("wrap_pc", PC_address, 32'h0);
        check("wrap_p4", IF_ID_PC_plus4, 32'h0);
`endif

        // reset overrides branch and stall
        cycle(1, 1, 1, 32'd64);
        check("rstbr_pc", PC_address, 32'h0);
        check("rstbr_cnt", fetch_count, 32'h0);
        check("rstbr_valid", 32'(IF_ID_valid), 32'd0);
        cycle(0, 0, 0, 0);
        check("post_rst_instr", IF_ID_instruction, 32'h02114020);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            logic r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            b = ($urandom_range(0, 99) < 15);
            s = ($urandom_range(0, 99) < 25);
            t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            cycle(r, s, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 SHALL have parameter MEM_BYTES, default 256: byte span of instruction memory, used only under PC_BOUNDS_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register (hazard stall).
REQ-006 SHALL have port branch_taken  input  1  redirect fetch this cycle.
REQ-007 SHALL have port branch_target  input  32  byte address of redirect.
REQ-008 SHALL have port instruction  input  32  word returned combinationally by instruction memory for PC_address.
REQ-009 SHALL have port PC_address  output  32  current fetch byte address, driven directly from PC register.
REQ-010 SHALL have port IF_ID_instruction  output  32  registered fetched word.
REQ-011 SHALL have port IF_ID_PC_plus4  output  32  registered PC+4 of that word.
REQ-012 SHALL have port IF_ID_valid  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-014 PC_address SHALL equal the PC register with zero combinational logic; instruction memory read is same-cycle.
REQ-015 Priority per edge SHALL be: reset > branch_taken > stall > normal fetch.
REQ-016 Normal fetch: PC <= PC+4; IF_ID_instruction <= instruction; IF_ID_PC_plus4 <= PC+4; IF_ID_valid <= 1; fetch_count += 1.
REQ-017 stall (no branch): PC, IF/ID outputs, fetch_count SHALL hold unchanged.
REQ-018 branch_taken: PC <= {branch_target[31:2],2'b00}; IF_ID_instruction <= 0; IF_ID_PC_plus4 <= 0; IF_ID_valid <= 0; fetch_count holds; applies even if stall=1.
REQ-019 Branch-to-fetch latency SHALL be 1 cycle: target word appears in IF/ID on the second edge after branch_taken is sampled.
REQ-020 PC[1:0] SHALL always be 2'b00.
REQ-021 PC+4 arithmetic SHALL be 32-bit modulo (without PC_BOUNDS_EN): 32'hFFFFFFFC wraps to 0.
REQ-022 fetch_count SHALL wrap 32'hFFFFFFFF -> 0 with no flag.
REQ-023 Fetch unit SHALL hold no other state; no multi-cycle handshake with memory.

Reset
REQ-024 On reset: PC <= RESET_PC with bits [1:0] forced 0; IF_ID_instruction <= 0; IF_ID_PC_plus4 <= 0; IF_ID_valid <= 0; fetch_count <= 0.
REQ-025 Reset asserted mid-stall or coincident with branch_taken SHALL override both.
REQ-026 First edge after reset release SHALL capture instruction at RESET_PC.

Configuration
REQ-027 Macro PC_BOUNDS_EN SHALL, when defined, wrap sequential PC to 0 when PC+4 >= MEM_BYTES, and mask branch targets modulo MEM_BYTES.
REQ-028 Without PC_BOUNDS_EN, PC SHALL be full 32-bit per REQ-021 and MEM_BYTES SHALL be unused.

Verification
REQ-029 Reset, then 2 free-running cycles, memory has 32'h02114020 @0, 32'h02534822 @4 -> IF/ID shows 02114020/PC_plus4=4, then 02534822/PC_plus4=8; PC_address=8; fetch_count=2.
REQ-030 stall=1 for 3 cycles at PC=8 -> PC_address stays 8, IF/ID and fetch_count unchanged; release -> resumes at 8.
REQ-031 branch_taken=1, branch_target=32 at PC=20 -> next cycle PC_address=32, IF_ID_valid=0; following cycle IF/ID holds word @32, PC_plus4=36.
REQ-032 branch_taken=1 with stall=1, target=32'h00000013 -> PC_address=32'h00000010, IF_ID_valid=0.
REQ-033 With PC_BOUNDS_EN, MEM_BYTES=256, PC=252 -> next PC_address=0; without it -> 256.
REQ-034 reset asserted one cycle while branch_taken=1, target=64 -> PC_address=RESET_PC, all IF/ID outputs and fetch_count zero.
